// File: rtl/game_round_sequencer.sv
// Round controller for the note-memory game: loads each stage's melody, starts the
// datapath, debounces the keypad into single strobes and tracks misses across four stages.
module game_round_sequencer #(
  parameter logic [31:0] SONG0           = 32'h0012_3456,
  parameter logic [31:0] SONG1           = 32'h0765_4321,
  parameter logic [31:0] SONG2           = 32'h0246_1357,
  parameter logic [31:0] SONG3           = 32'h0531_6420,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          TIMEOUT_CYCLES  = 500000000,
  parameter int          MAX_MISSES      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic [3:0]  keypad_raw,
  input  logic        game_end_in,
  input  logic        miss_in,
  output logic [31:0] data_out,
  output logic        write_enable,
  output logic        game_start,
  output logic        game_rst,
  output logic        keypad_enable,
  output logic [3:0]  keypad_code,
  output logic [1:0]  stage,
  output logic [1:0]  miss_count,
  output logic        busy,
  output logic        all_clear,
  output logic        game_over,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FLUSH       = 3'd1;
  localparam logic [2:0] S_LOAD        = 3'd2;
  localparam logic [2:0] S_ARM         = 3'd3;
  localparam logic [2:0] S_PLAY        = 3'd4;
  localparam logic [2:0] S_STAGE_CLEAR = 3'd5;
  localparam logic [2:0] S_GAME_OVER   = 3'd6;
  localparam logic [2:0] S_ALL_CLEAR   = 3'd7;

  localparam int              DB_W     = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [31:0]     TMO_MAX  = 32'(TIMEOUT_CYCLES);
  localparam logic [1:0]      MISS_MAX = 2'(MAX_MISSES);

  logic [2:0] state;

  // Bit layout of both synchroniser stages: {start, game_end, miss, key[3:0]}
  logic [6:0] sync1, sync2;
  logic [2:0] edge_prev;
  logic       start_edge, end_edge, miss_edge;
  logic [3:0] key_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      edge_prev <= '0;
    end else begin
      sync1     <= {start_btn, game_end_in, miss_in, keypad_raw};
      sync2     <= sync1;
      edge_prev <= sync2[6:4];
    end
  end

  assign start_edge = sync2[6] & ~edge_prev[2];
  assign end_edge   = sync2[5] & ~edge_prev[1];
  assign miss_edge  = sync2[4] & ~edge_prev[0];
  assign key_s      = sync2[3:0];

  logic [3:0]      cand;
  logic [DB_W-1:0] db_cnt;
  logic            armed, accepted, stable, key_acc;

  assign stable  = (key_s == cand) && (db_cnt == DB_MAX);
  assign key_acc = accepted && (state == S_PLAY);

  // A press is taken once per arm; re-arming needs a stable all-zero release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand          <= '0;
      db_cnt        <= '0;
      armed         <= 1'b0;
      accepted      <= 1'b0;
      keypad_code   <= '0;
      keypad_enable <= 1'b0;
    end else begin
      accepted <= 1'b0;
      if (key_s != cand) begin
        cand   <= key_s;
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (stable && armed && (cand != 4'd0)) begin
        keypad_code <= cand;
        accepted    <= 1'b1;
        armed       <= 1'b0;
      end else if (stable && !armed && (cand == 4'd0)) begin
        armed <= 1'b1;
      end
      keypad_enable <= key_acc;
    end
  end

  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  logic [1:0]  miss_inc;
  logic [31:0] song_sel;

  assign tmo_hit  = (TMO_MAX != 32'd0) && (tmo_cnt == TMO_MAX);
  assign miss_inc = (miss_count == 2'd3) ? 2'd3 : miss_count + 2'd1;

  always_comb begin
    song_sel = SONG0;
    case (stage)
      2'd0:    song_sel = SONG0;
      2'd1:    song_sel = SONG1;
      2'd2:    song_sel = SONG2;
      default: song_sel = SONG3;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      stage      <= '0;
      miss_count <= '0;
      data_out   <= '0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            stage      <= '0;
            miss_count <= '0;
            state      <= S_FLUSH;
          end
        end
        // data_out is staged here so it is already valid during the LOAD strobe
        S_FLUSH: begin
          data_out <= song_sel;
          state    <= S_LOAD;
        end
        S_LOAD: state <= S_ARM;
        S_ARM: begin
          tmo_cnt <= '0;
          state   <= S_PLAY;
        end
        S_PLAY: begin
          if (tmo_hit || key_acc)
            tmo_cnt <= '0;
          else if (tmo_cnt != 32'hFFFF_FFFF)
            tmo_cnt <= tmo_cnt + 32'd1;
          if (end_edge) begin
            state <= S_STAGE_CLEAR;
          end else if (miss_edge || tmo_hit) begin
            miss_count <= miss_inc;
            if (miss_inc == MISS_MAX)
              state <= S_GAME_OVER;
          end
        end
        S_STAGE_CLEAR: begin
          if (stage == 2'd3) begin
            state <= S_ALL_CLEAR;
          end else begin
            stage <= stage + 2'd1;
            state <= S_FLUSH;
          end
        end
        S_GAME_OVER, S_ALL_CLEAR: begin
          if (start_edge) begin
            stage      <= '0;
            miss_count <= '0;
            state      <= S_FLUSH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so a reset cancels them immediately.
  assign game_rst     = (state == S_FLUSH);
  assign write_enable = (state == S_LOAD);
  assign game_start   = (state == S_ARM);
  assign busy         = (state == S_FLUSH) || (state == S_LOAD) ||
                        (state == S_ARM)   || (state == S_PLAY);
  assign all_clear    = (state == S_ALL_CLEAR);
  assign game_over    = (state == S_GAME_OVER);
  assign state_dbg    = state;

endmodule

// File: doc/game_round_sequencer.md
Name: game_round_sequencer

Overview:
- Controller for the note-memory game datapath.
- Loads each stage's 32-bit melody word, issues the start pulse, and conditions raw keypad input into single-cycle keypad strobes.
- Counts misses and timeouts, and advances through four stages until all stages are cleared or the player is out of lives.
- Sits between the board I/O (start button, keypad) and the game datapath's data_in / write_enable / keypad_enable / game_start / reset / game_end / miss inputs.

Parameters:
- SONG0, 32'h0012_3456, melody word for stage 0; 3-bit note in bits [4k+2:4k], k = 0..7.
- SONG1, 32'h0765_4321, melody word for stage 1.
- SONG2, 32'h0246_1357, melody word for stage 2.
- SONG3, 32'h0531_6420, melody word for stage 3.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a key press or release.
- TIMEOUT_CYCLES, 500000000, cycles without an accepted press in PLAY before a timeout miss is counted; 0 disables the timeout.
- MAX_MISSES, 3, miss count that ends the game; legal range 1..3.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start_btn  input  1  raw start button, asynchronous, active-high
- keypad_raw  input  4  raw keypad code; 0 = no key
- game_end_in  input  1  stage-complete level from the datapath
- miss_in  input  1  miss level from the datapath
- data_out  output  32  melody word presented to the datapath
- write_enable  output  1  one-cycle load strobe for data_out
- game_start  output  1  one-cycle start strobe
- game_rst  output  1  one-cycle active-high reset to the datapath
- keypad_enable  output  1  one-cycle accepted-key strobe
- keypad_code  output  4  debounced key code; valid while keypad_enable = 1 and held afterwards
- stage  output  2  current stage index
- miss_count  output  2  misses in the current game
- busy  output  1  high in FLUSH, LOAD, ARM, PLAY
- all_clear  output  1  high in ALL_CLEAR
- game_over  output  1  high in GAME_OVER

Behaviour:

Reset and input synchronisation:
- reset low: every output and internal counter is 0; state = IDLE.
- start_btn, keypad_raw, game_end_in and miss_in each pass through a 2-FF synchroniser.
- start_btn, game_end_in and miss_in are used only as rising edges of the synchronised signal.

Keypad debounce (runs in every state):
- A candidate code equal to the synchronised keypad_raw is tracked together with a stability counter.
- Any change of code restarts the counter at 0.
- Press: a non-zero code that stays stable for DEBOUNCE_CYCLES cycles while armed causes keypad_code <= code and sets accepted, then disarms.
- keypad_enable is a one-cycle pulse on the cycle after accepted is set, and only if state = PLAY. Presses accepted outside PLAY are dropped.
- Release: re-arm only after code = 0 stays stable for DEBOUNCE_CYCLES cycles. Holding a key produces exactly one strobe.

FSM:
- IDLE: start edge -> FLUSH, with stage <= 0 and miss_count <= 0.
- FLUSH: game_rst = 1 for one cycle -> LOAD.
- LOAD: data_out = SONG[stage] (held until the next LOAD); write_enable = 1 for one cycle -> ARM.
- ARM: game_start = 1 for one cycle -> PLAY. The timeout counter clears.
- PLAY, priority order:
  1. game_end edge -> STAGE_CLEAR. A miss edge in the same cycle is ignored.
  2. Miss edge, or timeout counter reaching TIMEOUT_CYCLES (the counter then clears) -> miss_count + 1. If the new value equals MAX_MISSES -> GAME_OVER.
  3. An accepted keypad strobe clears the timeout counter.
  - A start edge in PLAY is ignored.
- STAGE_CLEAR (one cycle): if stage == 3 -> ALL_CLEAR with stage held at 3; otherwise stage + 1 -> FLUSH. miss_count is carried across stages.
- GAME_OVER / ALL_CLEAR: outputs hold. A start edge clears stage and miss_count -> FLUSH.

Latency and arithmetic:
- FLUSH -> LOAD -> ARM -> PLAY: game_rst, write_enable and game_start land on three consecutive cycles.
- miss_count saturates at 3 and never wraps.
- The timeout counter is 32 bits and saturates.
- Reset mid-game returns to IDLE immediately; in-flight strobes are cancelled.

Test Plan (DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 100, MAX_MISSES = 3):
- Reset, then a start pulse -> game_rst, write_enable with data_out = 32'h0012_3456, and game_start on 3 consecutive cycles; busy = 1; stage = 0.
- keypad_raw = 4'h3 held 50 cycles with one 2-cycle glitch to 4'h5 early -> exactly one keypad_enable with keypad_code = 3; no second strobe until a release of ≥4 stable cycles followed by a new press.
- In PLAY, pulse miss_in three times -> miss_count goes 1, 2, 3; GAME_OVER, game_over = 1, busy = 0; a further start pulse -> FLUSH with miss_count = 0 and stage = 0.
- game_end_in and miss_in rise in the same cycle -> miss_count unchanged, stage increments to 1, next LOAD shows data_out = 32'h0765_4321.
- No key press for 100 PLAY cycles -> miss_count + 1 and the timer restarts; a press at cycle 99 -> no miss.
- Clear stages 0..3 -> all_clear = 1 with stage = 3. Assert reset low mid-PLAY -> all outputs 0 in the same cycle.
